led_matrix_shifter: RTL and testbench

LED_MATRIX_SHIFTER -- requirements
Module: led_matrix_shifter

---
 rtl/led_matrix_shifter_if.sv | 31 +++
 rtl/led_matrix_shifter.sv | 212 +++++++++++++++++++++
 tb/tb_led_matrix_shifter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_shifter_if.sv
// Bundle of the shifter's control inputs and 74HC595 chain outputs.
// master: matrix controller side (drives row/column data, watches status).
// slave : led_matrix_shifter.
// The interface parameters must match the ones given to led_matrix_shifter.
interface led_matrix_shifter_if #(
    parameter int P_ROW_NUM     = 8,
    parameter int P_COLUMN_NUM  = 8,
    parameter int P_CONTROL_NUM = 3
);
    logic                     i_enable;
    logic                     i_force;
    logic [P_ROW_NUM-1:0]     i_row_anode;
    logic [P_CONTROL_NUM-1:0] i_column_cell [0:P_COLUMN_NUM-1];

    logic                     o_ser;
    logic                     o_sclk;
    logic                     o_rclk;
    logic                     o_oe_n;
    logic                     o_busy;
    logic                     o_frame_done;

    modport master (
        output i_enable, i_force, i_row_anode, i_column_cell,
        input  o_ser, o_sclk, o_rclk, o_oe_n, o_busy, o_frame_done
    );

    modport slave (
        input  i_enable, i_force, i_row_anode, i_column_cell,
        output o_ser, o_sclk, o_rclk, o_oe_n, o_busy, o_frame_done
    );
endinterface

// File: rtl/led_matrix_shifter.sv
// LED matrix shifter: serialises {row pattern, column colours} MSB-first into
// a 74HC595 chain, then pulses the storage latch. A frame starts from IDLE when
// enabled and a request is pending: forced, periodic refresh, or the assembled
// word differing from the word last shifted out.
//
// Build option: define LED_SHIFT_COL_INVERT_EN to invert every column bit in
// the frame word (common-anode column sinking). Row bits are never inverted.
// The change detector always compares post-inversion words.
//
// Outputs are registered; each output flop is loaded from the value the
// outputs must take in the next state, so the pins line up with the state.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for i_enable and a pending request
// LOAD     | 1 cycle: capture word into snapshot, clear pending, bit:=W-1
// SHIFT_LO | sclk low, ser = snapshot[bit], P_SCLK_DIV cycles
// SHIFT_HI | sclk high, P_SCLK_DIV cycles; bit 0 -> LATCH, else bit-1
// LATCH    | rclk high, P_SCLK_DIV cycles, then IDLE (+ frame_done pulse)
module led_matrix_shifter #(
    parameter int P_ROW_NUM        = 8,
    parameter int P_COLUMN_NUM     = 8,
    parameter int P_CONTROL_NUM    = 3,
    parameter int P_SCLK_DIV       = 4,
    parameter int P_REFRESH_CYCLES = 50_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_matrix_shifter_if.slave  bus
);
    localparam int W_COL = P_COLUMN_NUM * P_CONTROL_NUM;
    localparam int W     = P_ROW_NUM + W_COL;
    localparam int W_BIT = (W > 1) ? $clog2(W) : 1;
    localparam int W_DIV = (P_SCLK_DIV > 1) ? $clog2(P_SCLK_DIV) : 1;
    localparam int W_REF = (P_REFRESH_CYCLES > 1) ? $clog2(P_REFRESH_CYCLES) : 1;

    localparam logic [W_BIT-1:0] BIT_MSB  = W_BIT'(W - 1);
    localparam logic [W_DIV-1:0] DIV_LAST = W_DIV'(P_SCLK_DIV - 1);
    localparam logic [W_REF-1:0] REF_LAST = W_REF'(P_REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4
    } state_t;

    state_t           state_q, state_nxt;
    logic [W_DIV-1:0] div_q, div_nxt;
    logic [W_BIT-1:0] bit_q, bit_nxt;
    logic [W-1:0]     snap_q, snap_nxt;
    logic [W_REF-1:0] ref_q;
    logic             pend_q;

    logic             ser_q, sclk_q, rclk_q, oe_n_q, busy_q, done_q;
    logic             ser_nxt, sclk_nxt, rclk_nxt, oe_n_nxt, busy_nxt, done_nxt;

    logic [W_COL-1:0] col_bits;
    logic [W-1:0]     word_now;
    logic             ref_wrap;
    logic             pend_clr;
    logic             frame_end;
    logic             shifting_nxt;

    // Flatten the column array; column 0 sits directly below the row bits.
    always_comb begin
        col_bits = '0;
        for (int c = 0; c < P_COLUMN_NUM; c++) begin
            col_bits[(P_COLUMN_NUM-1-c)*P_CONTROL_NUM +: P_CONTROL_NUM] = bus.i_column_cell[c];
        end
    end

`ifdef LED_SHIFT_COL_INVERT_EN
    assign word_now = {bus.i_row_anode, ~col_bits};
`else
    assign word_now = {bus.i_row_anode, col_bits};
`endif

    assign ref_wrap = (ref_q == REF_LAST);

    // Free-running refresh counter, 0..P_REFRESH_CYCLES-1, independent of the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_q <= '0;
        end else if (ref_wrap) begin
            ref_q <= '0;
        end else begin
            ref_q <= ref_q + 1'b1;
        end
    end

    // Single pending flag; a new request in the LOAD cycle wins over the clear
    // so it is never lost. Starts set so the first frame goes out after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= 1'b1;
        end else if (bus.i_force || ref_wrap) begin
            pend_q <= 1'b1;
        end else if (pend_clr) begin
            pend_q <= 1'b0;
        end
    end

    // Next-state logic, datapath updates and next-cycle output values.
    always_comb begin
        state_nxt    = state_q;
        div_nxt      = div_q;
        bit_nxt      = bit_q;
        snap_nxt     = snap_q;
        pend_clr     = 1'b0;
        frame_end    = 1'b0;
        shifting_nxt = 1'b0;
        ser_nxt      = 1'b0;
        sclk_nxt     = 1'b0;
        rclk_nxt     = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        oe_n_nxt     = oe_n_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_enable && (pend_q || (word_now != snap_q))) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                snap_nxt  = word_now;
                bit_nxt   = BIT_MSB;
                div_nxt   = DIV_LAST;
                pend_clr  = 1'b1;
                state_nxt = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (div_q == '0) begin
                    div_nxt   = DIV_LAST;
                    state_nxt = ST_SHIFT_HI;
                end else begin
                    div_nxt = div_q - 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (div_q == '0) begin
                    div_nxt = DIV_LAST;
                    if (bit_q == '0) begin
                        state_nxt = ST_LATCH;
                    end else begin
                        bit_nxt   = bit_q - 1'b1;
                        state_nxt = ST_SHIFT_LO;
                    end
                end else begin
                    div_nxt = div_q - 1'b1;
                end
            end
            ST_LATCH: begin
                if (div_q == '0) begin
                    div_nxt   = DIV_LAST;
                    frame_end = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    div_nxt = div_q - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        shifting_nxt = (state_nxt == ST_SHIFT_LO) || (state_nxt == ST_SHIFT_HI);
        ser_nxt      = shifting_nxt && snap_nxt[bit_nxt];
        sclk_nxt     = (state_nxt == ST_SHIFT_HI);
        rclk_nxt     = (state_nxt == ST_LATCH);
        busy_nxt     = (state_nxt != ST_IDLE);
        done_nxt     = frame_end;
        // Outputs are enabled once the first valid word has been latched.
        oe_n_nxt     = oe_n_q && !frame_end;
    end

    // State, datapath and output registers; reset aborts any frame at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            snap_q  <= '0;
            ser_q   <= 1'b0;
            sclk_q  <= 1'b0;
            rclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_nxt;
            div_q   <= div_nxt;
            bit_q   <= bit_nxt;
            snap_q  <= snap_nxt;
            ser_q   <= ser_nxt;
            sclk_q  <= sclk_nxt;
            rclk_q  <= rclk_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            oe_n_q  <= oe_n_nxt;
        end
    end

    assign bus.o_ser        = ser_q;
    assign bus.o_sclk       = sclk_q;
    assign bus.o_rclk       = rclk_q;
    assign bus.o_oe_n       = oe_n_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_led_matrix_shifter.sv
// Testbench for led_matrix_shifter. Stimulus drives the interface; a monitor
// decodes each serial frame from the pins and checks it against a reference
// word queued when the frame's load cycle is seen. Build with or without
// LED_SHIFT_COL_INVERT_EN; the reference model follows the same macro.
module tb_led_matrix_shifter;
    localparam int P_ROW_NUM        = 8;
    localparam int P_COLUMN_NUM     = 8;
    localparam int P_CONTROL_NUM    = 3;
    localparam int P_SCLK_DIV       = 4;
    localparam int P_REFRESH_CYCLES = 3000;
    localparam int W_COL     = P_COLUMN_NUM * P_CONTROL_NUM;
    localparam int W         = P_ROW_NUM + W_COL;
    localparam int FRAME_LEN = 1 + 2 * P_SCLK_DIV * W + P_SCLK_DIV;

    // Column 5 carries the 3'b001 pattern: with column 0 directly below the
    // row byte, column 5's LSB is word bit 6 (0x40).
`ifdef LED_SHIFT_COL_INVERT_EN
    localparam logic [W-1:0] WORD_A = 32'h08FF_FFBF;
    localparam logic [W-1:0] WORD_B = 32'h20FF_FFBF;
`else
    localparam logic [W-1:0] WORD_A = 32'h0800_0040;
    localparam logic [W-1:0] WORD_B = 32'h2000_0040;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_matrix_shifter_if #(
        .P_ROW_NUM(P_ROW_NUM), .P_COLUMN_NUM(P_COLUMN_NUM), .P_CONTROL_NUM(P_CONTROL_NUM)
    ) bus ();

    led_matrix_shifter #(
        .P_ROW_NUM(P_ROW_NUM), .P_COLUMN_NUM(P_COLUMN_NUM), .P_CONTROL_NUM(P_CONTROL_NUM),
        .P_SCLK_DIV(P_SCLK_DIV), .P_REFRESH_CYCLES(P_REFRESH_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: row bits on top, then column 0..N-1 colour fields, optional
    // inversion of the whole column field.
    function automatic logic [W-1:0] model_word(input logic [P_ROW_NUM-1:0] row,
                                                input logic [P_CONTROL_NUM-1:0] cc [0:P_COLUMN_NUM-1]);
        longint colv;
        longint acc;
        colv = 0;
        for (int c = 0; c < P_COLUMN_NUM; c++) begin
            colv = colv * (longint'(1) << P_CONTROL_NUM) + longint'(cc[c]);
        end
`ifdef LED_SHIFT_COL_INVERT_EN
        colv = ((longint'(1) << W_COL) - 1) - colv;
`endif
        acc = longint'(row) * (longint'(1) << W_COL) + colv;
        return W'(acc);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] exp_q [$];
    logic [W-1:0] shreg, last_word, exp_w;
    int cyc = 0, rcyc = -1;
    int frames_started = 0, frames_done = 0;
    int sclk_cnt = 0, sclk_total = 0, rclk_len = 0;
    int t_load = 0, last_done_cyc = 0, gap = 0;
    logic prev_busy = 1'b0, prev_sclk = 1'b0, prev_rclk = 1'b0;
    logic latched_seen = 1'b0, rclk_fell;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            prev_busy = 1'b0; prev_sclk = 1'b0; prev_rclk = 1'b0;
            latched_seen = 1'b0; sclk_cnt = 0; rclk_len = 0; rcyc = -1;
        end else begin
            rcyc++;
            if (bus.o_busy && !prev_busy) begin
                exp_q.push_back(model_word(bus.i_row_anode, bus.i_column_cell));
                t_load = cyc; gap = cyc - last_done_cyc;
                sclk_cnt = 0; shreg = '0; frames_started++;
            end
            if (bus.o_sclk && !prev_sclk) begin
                shreg = {shreg[W-2:0], bus.o_ser};
                sclk_cnt++; sclk_total++;
            end
            if (bus.o_rclk) rclk_len++;
            rclk_fell = prev_rclk && !bus.o_rclk;
            if (rclk_fell) begin
                latched_seen = 1'b1;
                chk("sclk_edges", sclk_cnt, W);
                chk("rclk_width", rclk_len, P_SCLK_DIV);
                chk("frame_len", cyc - t_load, FRAME_LEN);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_frame");
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("frame_word", shreg, exp_w);
                end
                last_word = shreg; frames_done++; last_done_cyc = cyc; rclk_len = 0;
            end
            chk("frame_done_pulse", bus.o_frame_done, rclk_fell);
            chk("oe_n_state", bus.o_oe_n, !latched_seen);
            chk("ser_idle_zero", bus.o_ser && !bus.o_busy, 0);
            prev_busy = bus.o_busy; prev_sclk = bus.o_sclk; prev_rclk = bus.o_rclk;
        end
    end

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin tick; n++; end
        if (frames_done < target) fail_now(name);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.o_busy && n < 3 * FRAME_LEN) begin tick; n++; end
        if (bus.o_busy) fail_now(name);
    endtask

    task automatic pulse_force;
        bus.i_force = 1'b1;
        tick;
        bus.i_force = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base, base_s, n;
        logic [W-1:0] old_w;
        bus.i_enable = 1'b0; bus.i_force = 1'b0; bus.i_row_anode = '0;
        for (int c = 0; c < P_COLUMN_NUM; c++) bus.i_column_cell[c] = '0;
        repeat (3) tick;

        // Directed first frame after reset.
        bus.i_row_anode = 8'h08;
        bus.i_column_cell[5] = 3'b001;
        bus.i_enable = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_sclk", bus.o_sclk, 0);
        chk("rst_rclk", bus.o_rclk, 0);
        chk("rst_ser", bus.o_ser, 0);
        chk("rst_done", bus.o_frame_done, 0);
        chk("rst_oe_n", bus.o_oe_n, 1);
        @(negedge clk);
        chk("load_after_idle", bus.o_busy, 1);
        wait_done(1, FRAME_LEN + 10, "first_frame");
        chk("first_word", last_word, WORD_A);
        chk("oe_after_latch", bus.o_oe_n, 0);

        // Row change while shifting bit 20 of a forced frame.
        base = frames_done; base_s = frames_started;
        pulse_force;
        n = 0;
        while (!(frames_started == base_s + 1 && sclk_cnt == 12) && n < 2 * FRAME_LEN) begin tick; n++; end
        if (n >= 2 * FRAME_LEN) fail_now("wait_bit20");
        bus.i_row_anode = 8'h20;
        wait_done(base + 1, 2 * FRAME_LEN, "old_word_frame");
        chk("inflight_word", last_word, WORD_A);
        wait_done(base + 2, 2 * FRAME_LEN, "new_word_frame");
        chk("changed_word", last_word, WORD_B);
        chk("restart_gap", gap, 1);

        // Reset at the tenth sclk rising edge of a frame.
        wait_idle("idle_before_reset");
        base = frames_done; base_s = frames_started;
        pulse_force;
        n = 0;
        while (!(frames_started == base_s + 1 && sclk_cnt == 10) && n < 2 * FRAME_LEN) begin tick; n++; end
        if (n >= 2 * FRAME_LEN) fail_now("wait_sclk10");
        rst_n = 1'b0;
        tick;
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_sclk", bus.o_sclk, 0);
        chk("abort_rclk", bus.o_rclk, 0);
        chk("abort_ser", bus.o_ser, 0);
        chk("abort_done", bus.o_frame_done, 0);
        chk("abort_oe_n", bus.o_oe_n, 1);
        tick;
        chk("abort_no_latch", frames_done, base);
        rst_n = 1'b1;
        wait_done(base + 1, FRAME_LEN + 10, "post_reset_frame");
        chk("post_reset_word", last_word, WORD_B);

        // Force, refresh wrap and data change all land in one busy frame.
        wait_idle("idle_before_merge");
        n = 0;
        while ((rcyc % P_REFRESH_CYCLES) != P_REFRESH_CYCLES - 150 && n < 2 * P_REFRESH_CYCLES) begin tick; n++; end
        base = frames_done; base_s = frames_started;
        pulse_force;
        n = 0;
        while (!(frames_started == base_s + 1 && sclk_cnt >= 10) && n < 2 * FRAME_LEN) begin tick; n++; end
        if (n >= 2 * FRAME_LEN) fail_now("wait_merge_frame");
        bus.i_column_cell[0] = bus.i_column_cell[0] ^ 3'b101;
        pulse_force;
        wait_done(base + 2, 3 * FRAME_LEN, "merged_follow");
        chk("merged_gap", gap, 1);
        repeat (1000) tick;
        chk("merged_frames_done", frames_done - base, 2);
        chk("merged_frames_started", frames_started - base_s, 2);

        // Enable low across three refresh periods: no activity, then prompt start.
        wait_idle("idle_before_disable");
        bus.i_enable = 1'b0;
        tick;
        base = frames_done; base_s = sclk_total; n = frames_started;
        repeat (3 * P_REFRESH_CYCLES) tick;
        chk("disabled_sclk", sclk_total - base_s, 0);
        chk("disabled_starts", frames_started - n, 0);
        bus.i_enable = 1'b1;
        n = 0;
        while (!bus.o_busy && n < 2) begin tick; n++; end
        chk("enable_start", bus.o_busy, 1);
        wait_done(base + 1, FRAME_LEN + 10, "enable_frame");

        // Randomised words, sometimes forced, checked by the scoreboard.
        for (int it = 0; it < 12; it++) begin
            wait_idle("idle_rand");
            old_w = model_word(bus.i_row_anode, bus.i_column_cell);
            bus.i_row_anode = P_ROW_NUM'($urandom);
            for (int c = 0; c < P_COLUMN_NUM; c++) bus.i_column_cell[c] = P_CONTROL_NUM'($urandom);
            base = frames_done;
            if (model_word(bus.i_row_anode, bus.i_column_cell) == old_w || $urandom_range(0, 2) == 0)
                pulse_force;
            wait_done(base + 1, 2 * FRAME_LEN, "rand_frame");
        end

        wait_idle("idle_final");
        repeat (5) tick;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
